// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the mem write arbiter.
// Holds the FSM state encoding, the mem data width and the round-robin
// pointer wrap helper used by mem_wr_arbiter and mem_rr_pick.
package mem_arb_pkg;

   // Arbiter FSM states: grant in IDLE, hold the write in WRITE,
   // drain the mem ack in RELEASE.
   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      WRITE   = 2'd1,
      RELEASE = 2'd2
   } arb_state_e;

   // Width of the mem write register.
   localparam int MEM_DW = 6;

   // Pointer / index width; wide enough for up to 8 requesters.
   localparam int PTR_W = 3;

   // Next round-robin pointer position, wrapping n-1 -> 0.
   function automatic logic [PTR_W-1:0] rr_next(input logic [PTR_W-1:0] ptr,
                                                input int n);
      logic [PTR_W-1:0] nxt;
      if (int'(ptr) >= n - 1) begin
         nxt = '0;
      end else begin
         nxt = ptr + {{(PTR_W-1){1'b0}}, 1'b1};
      end
      return nxt;
   endfunction

endpackage

// File: rtl/mem_rr_pick.sv
// Combinational round-robin picker.
// Scans the request vector starting at the pointer position, wrapping past
// N_REQ-1 back to 0, and reports the first set bit as a one-hot grant, its
// index, and whether any request was present at all.
module mem_rr_pick
   import mem_arb_pkg::*;
#(
   parameter int N_REQ = 4
) (
   input  logic [N_REQ-1:0] req,
   input  logic [PTR_W-1:0] ptr,
   output logic [N_REQ-1:0] grant,
   output logic [PTR_W-1:0] idx,
   output logic             any
);

   int cand;

   // Walk the requesters in priority order starting at ptr; first hit wins.
   always_comb begin
      grant = '0;
      idx   = '0;
      any   = 1'b0;
      cand  = 0;
      for (int k = 0; k < N_REQ; k++) begin
         cand = int'(ptr) + k;
         if (cand >= N_REQ) begin
            cand = cand - N_REQ;
         end
         if (!any && req[cand]) begin
            any         = 1'b1;
            grant[cand] = 1'b1;
            idx         = PTR_W'(cand);
         end
      end
   end

endmodule

// File: rtl/mem_wr_arbiter.sv
// Round-robin arbiter giving N_REQ tester channels shared access to the
// single mem write register. A granted write is held on out_mem_data /
// out_mem_en until mem acknowledges with in_mem_rd, then the winner gets a
// one-cycle req_done pulse. The FSM then waits for the ack to drop before
// granting again, so a stale ack can never complete the next write.
//
// Handshake: a requester raises req_vld with its data and holds both until
// its req_done (or req_err) pulse; towards mem, out_mem_en is held high with
// stable out_mem_data until in_mem_rd is seen high.
//
// Optional build macro WR_TIMEOUT_EN: abort a write after TMO_CYC cycles
// without in_mem_rd and pulse req_err to the winner instead of req_done.
// Without the macro req_err is constant 0 and WRITE waits indefinitely.
module mem_wr_arbiter
   import mem_arb_pkg::*;
#(
   parameter int N_REQ   = 4,
   parameter int DW      = MEM_DW,
   parameter int TMO_CYC = 15
) (
   input  logic              in_clk,
   input  logic              in_rst,
   input  logic [N_REQ-1:0]  req_vld,
   input  logic [N_REQ*DW-1:0] req_data,
   output logic [N_REQ-1:0]  req_done,
   output logic [N_REQ-1:0]  req_err,
   output logic [DW-1:0]     out_mem_data,
   output logic              out_mem_en,
   input  logic              in_mem_rd,
   output logic              busy
);

   localparam logic [N_REQ-1:0] ONE_HOT0 = {{(N_REQ-1){1'b0}}, 1'b1};

   arb_state_e        state_q;
   logic [PTR_W-1:0]  rr_ptr_q;
   logic [PTR_W-1:0]  win_idx_q;

   logic [N_REQ-1:0]  pick_grant;
   logic [PTR_W-1:0]  pick_idx;
   logic              pick_any;
   logic [DW-1:0]     pick_data;

   mem_rr_pick #(
      .N_REQ (N_REQ)
   ) u_pick (
      .req   (req_vld),
      .ptr   (rr_ptr_q),
      .grant (pick_grant),
      .idx   (pick_idx),
      .any   (pick_any)
   );

   // Data slice of the requester the picker currently favours.
   always_comb begin
      pick_data = req_data[int'(pick_idx)*DW +: DW];
   end

`ifdef WR_TIMEOUT_EN
   localparam int TMO_W = $clog2(TMO_CYC + 1);
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_CYC - 1);

   logic [TMO_W-1:0] tmo_cnt_q;

   // Arbiter FSM with write timeout: grant, hold until ack or timeout, drain ack.
   always_ff @(posedge in_clk) begin
      if (!in_rst) begin
         state_q      <= IDLE;
         rr_ptr_q     <= '0;
         win_idx_q    <= '0;
         out_mem_data <= '0;
         out_mem_en   <= 1'b0;
         req_done     <= '0;
         req_err      <= '0;
         busy         <= 1'b0;
         tmo_cnt_q    <= '0;
      end else begin
         req_done <= '0;
         req_err  <= '0;
         case (state_q)
            IDLE: begin
               if (pick_any && !in_mem_rd) begin
                  win_idx_q    <= pick_idx;
                  out_mem_data <= pick_data;
                  out_mem_en   <= 1'b1;
                  busy         <= 1'b1;
                  tmo_cnt_q    <= '0;
                  state_q      <= WRITE;
               end
            end
            WRITE: begin
               if (in_mem_rd) begin
                  out_mem_en <= 1'b0;
                  req_done   <= ONE_HOT0 << win_idx_q;
                  rr_ptr_q   <= rr_next(win_idx_q, N_REQ);
                  state_q    <= RELEASE;
               end else if (tmo_cnt_q == TMO_LAST) begin
                  out_mem_en <= 1'b0;
                  req_err    <= ONE_HOT0 << win_idx_q;
                  rr_ptr_q   <= rr_next(win_idx_q, N_REQ);
                  state_q    <= RELEASE;
               end else begin
                  tmo_cnt_q <= tmo_cnt_q + {{(TMO_W-1){1'b0}}, 1'b1};
               end
            end
            RELEASE: begin
               if (!in_mem_rd) begin
                  busy    <= 1'b0;
                  state_q <= IDLE;
               end
            end
            default: begin
               out_mem_en <= 1'b0;
               busy       <= 1'b0;
               state_q    <= IDLE;
            end
         endcase
      end
   end
`else
   // No abort path: the error pulse never fires.
   assign req_err = '0;

   // Arbiter FSM: grant, hold until ack, drain ack.
   always_ff @(posedge in_clk) begin
      if (!in_rst) begin
         state_q      <= IDLE;
         rr_ptr_q     <= '0;
         win_idx_q    <= '0;
         out_mem_data <= '0;
         out_mem_en   <= 1'b0;
         req_done     <= '0;
         busy         <= 1'b0;
      end else begin
         req_done <= '0;
         case (state_q)
            IDLE: begin
               if (pick_any && !in_mem_rd) begin
                  win_idx_q    <= pick_idx;
                  out_mem_data <= pick_data;
                  out_mem_en   <= 1'b1;
                  busy         <= 1'b1;
                  state_q      <= WRITE;
               end
            end
            WRITE: begin
               if (in_mem_rd) begin
                  out_mem_en <= 1'b0;
                  req_done   <= ONE_HOT0 << win_idx_q;
                  rr_ptr_q   <= rr_next(win_idx_q, N_REQ);
                  state_q    <= RELEASE;
               end
            end
            RELEASE: begin
               if (!in_mem_rd) begin
                  busy    <= 1'b0;
                  state_q <= IDLE;
               end
            end
            default: begin
               out_mem_en <= 1'b0;
               busy       <= 1'b0;
               state_q    <= IDLE;
            end
         endcase
      end
   end
`endif

endmodule
